// File: rtl/ultrasonic_ranger_multi.sv
// Round-robin HC-SR04 controller: triggers N_CH sensors in turn, times each echo in
// centimetres and reports missing or over-long echoes as timeouts on a valid-strobe stream.
module ultrasonic_ranger_multi #(
    parameter int CLK_HZ     = 27_000_000,
    parameter int N_CH       = 2,
    parameter int DIST_W     = 16,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 30000,
    parameter int GAP_US     = 10000,
    parameter int US_PER_CM  = 58,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [N_CH-1:0]   trig,
    input  logic [N_CH-1:0]   echo,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [DIST_W-1:0] out_dist,
    output logic              out_timeout,
    output logic              busy
);
    localparam int US_DIV = CLK_HZ / 1_000_000;
    localparam int DIV_W  = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(US_DIV - 1);
    localparam logic [31:0]      TRIG_LAST = 32'(TRIG_US - 1);
    localparam logic [31:0]      TMO_LAST  = 32'(TIMEOUT_US - 1);
    localparam logic [31:0]      GAP_LAST  = 32'(GAP_US - 1);
    localparam logic [31:0]      CM_LAST   = 32'(US_PER_CM - 1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, REPORT, GAP} state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [N_CH-1:0]     echo_s1_q, echo_s2_q;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [31:0]         us_q, us_d;
    logic [31:0]         cmdiv_q, cmdiv_d;
    logic [DIST_W-1:0]   cm_q, cm_d;
    logic [CH_W-1:0]     out_ch_q;
    logic [DIST_W-1:0]   out_dist_q;
    logic                out_tmo_q;
    logic                rpt_tmo;
    logic                us_tick;
    logic                echo_sel;

    assign us_tick  = (div_q == DIV_LAST);
    assign echo_sel = echo_s2_q[ch_q];

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        rpt_tmo = 1'b0;
        case (state_q)
            IDLE:      if (en) state_d = TRIG;
            TRIG:      if (us_tick && us_q == TRIG_LAST) state_d = WAIT_RISE;
            WAIT_RISE: begin
                if (echo_sel) begin
                    state_d = MEASURE;
                end else if (us_tick && us_q == TMO_LAST) begin
                    state_d = REPORT;
                    rpt_tmo = 1'b1;
                end
            end
            MEASURE: begin
                if (!echo_sel) begin
                    state_d = REPORT;
                end else if (us_tick && us_q == TMO_LAST) begin
                    state_d = REPORT;
                    rpt_tmo = 1'b1;
                end
            end
            REPORT:    state_d = GAP;
            GAP: begin
                if (us_tick && us_q == GAP_LAST) begin
                    ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
                    state_d = en ? TRIG : IDLE;
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    // Time base restarts on every state change so each state measures from its own entry.
    always_comb begin
        div_d   = us_tick ? '0 : div_q + DIV_W'(1);
        us_d    = us_tick ? us_q + 32'd1 : us_q;
        cmdiv_d = cmdiv_q;
        cm_d    = cm_q;
        if (state_d != state_q) begin
            div_d = '0;
            us_d  = '0;
        end
        if (state_d == MEASURE && state_q != MEASURE) begin
            cmdiv_d = '0;
            cm_d    = '0;
        end else if (state_q == MEASURE && us_tick) begin
            cmdiv_d = (cmdiv_q == CM_LAST) ? '0 : cmdiv_q + 32'd1;
            if (cmdiv_q == CM_LAST && cm_q != '1) cm_d = cm_q + DIST_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_s1_q <= '0;
            echo_s2_q <= '0;
        end else begin
            echo_s1_q <= echo;
            echo_s2_q <= echo_s1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            div_q      <= '0;
            us_q       <= '0;
            cmdiv_q    <= '0;
            cm_q       <= '0;
            out_ch_q   <= '0;
            out_dist_q <= '0;
            out_tmo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            div_q   <= div_d;
            us_q    <= us_d;
            cmdiv_q <= cmdiv_d;
            cm_q    <= cm_d;
            // cm_d includes a centimetre completed in the very cycle the fall is seen.
            if (state_d == REPORT) begin
                out_ch_q   <= ch_q;
                out_dist_q <= rpt_tmo ? '1 : cm_d;
                out_tmo_q  <= rpt_tmo;
            end
        end
    end

    always_comb begin
        trig = '0;
        if (state_q == TRIG) trig[ch_q] = 1'b1;
    end

    assign out_valid   = (state_q == REPORT);
    assign out_ch      = out_ch_q;
    assign out_dist    = out_dist_q;
    assign out_timeout = out_tmo_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ultrasonic_ranger_multi.sv
// Directed bench for ultrasonic_ranger_multi at 2 MHz with three sensors.
module tb_ultrasonic_ranger_multi;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  trig;
    logic [2:0]  echo;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [15:0] out_dist;
    logic        out_timeout;
    logic        busy;

    int checks = 0;
    int passed = 0;
    int overlap = 0;

    ultrasonic_ranger_multi #(
        .CLK_HZ(2_000_000), .N_CH(3), .DIST_W(16), .TRIG_US(10),
        .TIMEOUT_US(3000), .GAP_US(100), .US_PER_CM(58)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .trig(trig), .echo(echo),
        .out_valid(out_valid), .out_ch(out_ch), .out_dist(out_dist),
        .out_timeout(out_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if ($countones(trig) > 1) overlap++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_trig(input int bound, output int n);
        n = 0;
        while (trig == 3'b000 && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_trig_low(input int bound, output int n);
        n = 0;
        while (trig != 3'b000 && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_valid(input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < bound);
    endtask

    initial begin
        int n;
        int w;
        int seen;
        rst  = 1'b1;
        en   = 1'b0;
        echo = 3'b000;
        repeat (3) @(negedge clk);
        check("rst_trig", trig, 3'b000);
        check("rst_valid", out_valid, 1'b0);
        check("rst_ch", out_ch, 2'd0);
        check("rst_dist", out_dist, 16'd0);
        check("rst_timeout", out_timeout, 1'b0);
        check("rst_busy", busy, 1'b0);

        // Channel 0: 580 us echo starting 200 us after the trigger
        rst = 1'b0;
        en  = 1'b1;
        wait_trig(10, n);
        check("t1_trig_sel", trig, 3'b001);
        w = 0;
        while (trig[0] && w < 100) begin
            w++;
            @(negedge clk);
        end
        check("t1_trig_width", w, 20);
        repeat (400) @(negedge clk);
        echo[0] = 1'b1;
        repeat (1160) @(negedge clk);
        echo[0] = 1'b0;
        wait_valid(20, n);
        check("t1_latency", n, 3);
        check("t1_ch", out_ch, 2'd0);
        check("t1_dist", out_dist, 16'd10);
        check("t1_timeout", out_timeout, 1'b0);
        @(negedge clk);
        check("t1_strobe_len", out_valid, 1'b0);
        check("t1_dist_hold", out_dist, 16'd10);

        // Channel 1: no echo at all
        wait_trig(400, n);
        check("t2_trig_sel", trig, 3'b010);
        wait_trig_low(40, n);
        wait_valid(7000, n);
        check("t2_latency", n, 6000);
        check("t2_ch", out_ch, 2'd1);
        check("t2_dist", out_dist, 16'hFFFF);
        check("t2_timeout", out_timeout, 1'b1);

        // Channel 2: echo stuck high beyond the timeout
        wait_trig(400, n);
        check("t3_trig_sel", trig, 3'b100);
        wait_trig_low(40, n);
        echo[2] = 1'b1;
        wait_valid(7000, n);
        check("t3_latency", n, 6003);
        check("t3_ch", out_ch, 2'd2);
        check("t3_dist", out_dist, 16'hFFFF);
        check("t3_timeout", out_timeout, 1'b1);

        // Channel 0 again, echo[2] still high; en dropped mid-measurement
        wait_trig(400, n);
        check("t4_trig_sel", trig, 3'b001);
        wait_trig_low(40, n);
        repeat (1800) @(negedge clk);
        echo[2] = 1'b0;
        echo[0] = 1'b1;
        repeat (100) @(negedge clk);
        en = 1'b0;
        repeat (132) @(negedge clk);
        echo[0] = 1'b0;
        wait_valid(20, n);
        check("t6_latency", n, 3);
        check("t4_ch_wrap", out_ch, 2'd0);
        check("t6_dist", out_dist, 16'd2);
        check("t6_timeout", out_timeout, 1'b0);
        repeat (300) @(negedge clk);
        check("t6_busy", busy, 1'b0);
        seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (trig != 3'b000) seen++;
        end
        check("t6_no_trig", seen, 0);

        // Reset in the middle of a trigger pulse
        en = 1'b1;
        wait_trig(10, n);
        check("t5_trig_sel", trig, 3'b010);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_trig", trig, 3'b000);
        check("t5_valid", out_valid, 1'b0);
        check("t5_ch", out_ch, 2'd0);
        check("t5_dist", out_dist, 16'd0);
        check("t5_timeout", out_timeout, 1'b0);
        check("t5_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        wait_trig(10, n);
        check("t5_restart_ch0", trig, 3'b001);

        check("trig_onehot", overlap, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
